line_fill_responder: RTL and testbench

Next-level line-fill responder: the receiving end of the line-address requests that the L1 data and instruction caches emit on a read or write miss. It accepts 26-bit line addresses (address bits 31:6) through a valid/ready handshake and buffers them in an in-order FIFO. It services one request at a time through a fixed-latency memory model, then returns a one-cycle fill pulse carrying the serviced line address. It also keeps fill and coalesce counters for the statistics module.

---
 rtl/line_fill_responder.sv | 168 ++++++++++++++++
 tb/tb_line_fill_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_responder.sv
`default_nettype none
// ============================================================================
// Module   : line_fill_responder
// Brief    : Next-level line-fill responder. Queues L1 miss line addresses in
//            an in-order FIFO, services them one at a time with a fixed
//            latency and returns a one-cycle fill pulse per serviced line.
//            Optional request merging: LINE_FILL_COALESCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module line_fill_responder #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [25:0] req_addr,
    output logic        req_ready,
    output logic        fill_valid,
    output logic [25:0] fill_addr,
    output logic        busy,
    output logic [31:0] fills,
    output logic [31:0] coalesced
);

    localparam int c_PTR_W    = $clog2(DEPTH);
    localparam int c_CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int c_LOAD_INT = LATENCY - 1;

    localparam logic [c_PTR_W:0]   c_FULL     = DEPTH[c_PTR_W:0];
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_LOAD_INT[c_CNT_W-1:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [25:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_occ;
    logic [c_CNT_W-1:0] r_cnt;
    logic [25:0]        r_cur_addr;
    logic               r_fill_valid;
    logic [25:0]        r_fill_addr;
    logic [31:0]        r_fills;

    logic w_accept;
    logic w_hit;
    logic w_push;
    logic w_pop;

    // Ready depends on occupancy alone, so a pop on a full edge frees the
    // slot only for the following cycle.
    assign req_ready = (r_occ != c_FULL);
    assign w_accept  = req_valid && req_ready;
    assign w_push    = w_accept && !w_hit;
    assign w_pop     = (r_state != ST_BUSY) && (r_occ != '0);

`ifdef LINE_FILL_COALESCE_EN
    logic [DEPTH-1:0] w_entry_hit;
    logic [31:0]      r_coalesced;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        logic [c_PTR_W-1:0] w_slot;
        // Distance from the head decides whether this slot holds a live entry.
        assign w_slot         = c_PTR_W'(i) - r_rd_ptr;
        assign w_entry_hit[i] = ({1'b0, w_slot} < r_occ) && (r_mem[i] == req_addr);
    end

    assign w_hit = (|w_entry_hit) ||
                   ((r_state != ST_IDLE) && (r_cur_addr == req_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coalesced <= '0;
        end else if (w_accept && w_hit) begin
            r_coalesced <= r_coalesced + 32'd1;
        end
    end

    assign coalesced = r_coalesced;
`else
    assign w_hit     = 1'b0;
    assign coalesced = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= req_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_cur_addr   <= '0;
            r_fill_valid <= 1'b0;
            r_fill_addr  <= '0;
            r_fills      <= '0;
        end else begin
            r_fill_valid <= 1'b0;
            r_fill_addr  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_cur_addr <= r_mem[r_rd_ptr];
                        r_cnt      <= c_CNT_LOAD;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state      <= ST_RESP;
                        r_fill_valid <= 1'b1;
                        r_fill_addr  <= r_cur_addr;
                        r_fills      <= r_fills + 32'd1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    // Queued work goes straight back into service.
                    if (w_pop) begin
                        r_cur_addr <= r_mem[r_rd_ptr];
                        r_cnt      <= c_CNT_LOAD;
                        r_state    <= ST_BUSY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fill_valid = r_fill_valid;
    assign fill_addr  = r_fill_addr;
    assign fills      = r_fills;
    assign busy       = (r_state != ST_IDLE) || (r_occ != '0);

endmodule
`default_nettype wire

// File: tb/tb_line_fill_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_fill_responder
// Brief    : Self-checking bench for line_fill_responder (DEPTH=4, LATENCY=8
//            and LATENCY=1 instances). Honours LINE_FILL_COALESCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_fill_responder;

    localparam int DEPTH = 4;
    localparam int LAT_A = 8;
    localparam int LAT_B = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_valid = 1'b0;
    logic [25:0] a_addr  = '0;
    logic        a_ready, a_fv, a_busy;
    logic [25:0] a_fa;
    logic [31:0] a_fills, a_coal;

    logic        b_valid = 1'b0;
    logic [25:0] b_addr  = '0;
    logic        b_ready, b_fv, b_busy;
    logic [25:0] b_fa;
    logic [31:0] b_fills, b_coal;

    always #5 clk = ~clk;

    line_fill_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_addr(a_addr),
        .req_ready(a_ready), .fill_valid(a_fv), .fill_addr(a_fa),
        .busy(a_busy), .fills(a_fills), .coalesced(a_coal)
    );

    line_fill_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_addr(b_addr),
        .req_ready(b_ready), .fill_valid(b_fv), .fill_addr(b_fa),
        .busy(b_busy), .fills(b_fills), .coalesced(b_coal)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [25:0] fq[$];
    int          fe[$];

    // Reference model for the LATENCY=8 instance: a queue of pending lines and
    // a single server; a line popped at edge P fills at P+LAT and the server
    // can take new work from edge P+LAT+1 onward.
    logic [25:0] mq[$];
    bit          m_svc;
    int          m_last_pop;
    int          m_n;
    logic [25:0] m_addr;
    int unsigned m_fills, m_coal;
    bit          m_fv, m_busy;

    typedef struct {
        bit          v;
        logic [25:0] a;
        bit          fv;
        logic [25:0] fa;
        bit          rdy;
        bit          busy;
        int unsigned fills;
    } vec_t;

    vec_t        tbl[20];
    int          acc_e[$];
    int          exp_acc[6] = '{0, 1, 2, 3, 4, 11};
    logic [25:0] exp4[3];
    int          exp4_n;
    int          exp4_coal;
    int          base, idx, k;
    bit          acc, busy10;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_svc      = 1'b0;
        m_last_pop = 0;
        m_n        = 0;
        m_addr     = '0;
        m_fills    = 0;
        m_coal     = 0;
        m_fv       = 1'b0;
        m_busy     = 1'b0;
    endfunction

    function automatic void model_edge(input bit v, input logic [25:0] a);
        bit accept, hit, can_start;
        accept    = v && (mq.size() < DEPTH);
        can_start = !m_svc || (m_n >= m_last_pop + LAT_A + 1);
        hit       = 1'b0;
`ifdef LINE_FILL_COALESCE_EN
        if (accept) begin
            if (m_svc && (m_n <= m_last_pop + LAT_A + 1) && (m_addr == a)) hit = 1'b1;
            foreach (mq[i]) if (mq[i] == a) hit = 1'b1;
        end
`endif
        if (can_start && mq.size() > 0) begin
            m_addr     = mq.pop_front();
            m_svc      = 1'b1;
            m_last_pop = m_n;
        end
        if (accept) begin
            if (hit) m_coal++;
            else     mq.push_back(a);
        end
        m_fv   = m_svc && (m_n == m_last_pop + LAT_A);
        m_busy = (mq.size() > 0) || (m_svc && (m_n <= m_last_pop + LAT_A));
        if (m_fv) m_fills++;
        m_n++;
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_edge(a_valid, a_addr);
        #1;
        if (a_fv) begin
            fq.push_back(a_fa);
            fe.push_back(cyc);
        end
        if (!rst) begin
            check("A.fill", {37'd0, a_fv, a_fa}, {37'd0, m_fv, (m_fv ? m_addr : 26'd0)});
            check("A.hs", {62'd0, a_ready, a_busy}, {62'd0, (mq.size() < DEPTH), m_busy});
            check("A.cnt", {a_fills, a_coal}, {m_fills, m_coal});
        end
        cyc++;
    endtask

    task automatic do_reset();
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst     = 1'b1;
        model_reset();
        cycle();
        cycle();
        #3 rst = 1'b0;
        fq.delete();
        fe.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < 20; c++) begin
            tbl[c].v     = (c % 2 == 0) && (c < 18);
            tbl[c].a     = tbl[c].v ? 26'(100 + c / 2) : 26'd0;
            tbl[c].fv    = (c % 2 == 0) && (c >= 2) && (c <= 18);
            tbl[c].fa    = tbl[c].fv ? 26'(100 + (c - 2) / 2) : 26'd0;
            tbl[c].rdy   = 1'b1;
            tbl[c].busy  = (c <= 18);
            tbl[c].fills = (c < 2) ? 0 : (((c > 18 ? 18 : c) - 2) / 2 + 1);
        end
`ifdef LINE_FILL_COALESCE_EN
        exp4      = '{26'h10, 26'h20, 26'h0};
        exp4_n    = 2;
        exp4_coal = 1;
`else
        exp4      = '{26'h10, 26'h10, 26'h20};
        exp4_n    = 3;
        exp4_coal = 0;
`endif

        do_reset();
        check("A.rst_fill", {37'd0, a_fv, a_fa}, 64'd0);
        check("A.rst_hs", {62'd0, a_ready, a_busy}, 64'd2);
        check("A.rst_cnt", {a_fills, a_coal}, 64'd0);
        check("B.rst_fill", {37'd0, b_fv, b_fa}, 64'd0);
        check("B.rst_hs", {62'd0, b_ready, b_busy}, 64'd2);
        check("B.rst_cnt", {b_fills, b_coal}, 64'd0);

        // LATENCY=1: a request every other edge, nine of them to wrap pointers.
        for (int c = 0; c < 20; c++) begin
            b_valid = tbl[c].v;
            b_addr  = tbl[c].a;
            cycle();
            check("B.fill", {37'd0, b_fv, b_fa}, {37'd0, tbl[c].fv, tbl[c].fa});
            check("B.hs", {62'd0, b_ready, b_busy}, {62'd0, tbl[c].rdy, tbl[c].busy});
            check("B.fills", {32'd0, b_fills}, {32'd0, tbl[c].fills});
        end
        b_valid = 1'b0;
        check("B.coal", {32'd0, b_coal}, 64'd0);

        // Single request latency.
        do_reset();
        a_addr  = 26'h0ABCDEF;
        a_valid = 1'b1;
        base    = cyc;
        cycle();
        a_valid = 1'b0;
        busy10  = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            cycle();
            if (j == 10) busy10 = a_busy;
        end
        check("t1.nfill", 64'(fq.size()), 64'd1);
        if (fq.size() > 0) begin
            check("t1.edge", 64'(fe[0] - base), 64'd9);
            check("t1.addr", {38'd0, fq[0]}, {38'd0, 26'h0ABCDEF});
        end
        check("t1.fills", {32'd0, a_fills}, 64'd1);
        check("t1.busy_e10", {63'd0, busy10}, 64'd0);

        // Six requests against a 4-deep FIFO with valid held high.
        do_reset();
        acc_e.delete();
        idx     = 1;
        k       = 0;
        base    = cyc;
        a_valid = 1'b1;
        while (idx <= 6 && k < 40) begin
            a_addr = 26'(idx);
            acc    = a_ready;
            cycle();
            if (acc) begin
                acc_e.push_back(k);
                idx++;
            end
            k++;
        end
        a_valid = 1'b0;
        k = 0;
        while (fq.size() < 6 && k < 80) begin
            cycle();
            k++;
        end
        for (int i = 0; i < 6; i++)
            check("t2.accept_edge", 64'(i < acc_e.size() ? acc_e[i] : -1), 64'(exp_acc[i]));
        check("t2.nfill", 64'(fq.size()), 64'd6);
        if (fq.size() == 6) begin
            check("t2.first_edge", 64'(fe[0] - base), 64'd9);
            for (int i = 0; i < 6; i++)
                check("t2.addr", {38'd0, fq[i]}, {38'd0, 26'(i + 1)});
            for (int i = 1; i < 6; i++)
                check("t2.spacing", 64'(fe[i] - fe[i-1]), 64'd9);
        end

        // Asynchronous reset in the middle of a service with 3 lines queued.
        do_reset();
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_addr = 26'h100 + 26'(i);
            cycle();
        end
        a_valid = 1'b0;
        check("t3.busy_pre", {63'd0, a_busy}, 64'd1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("t3.rst_fill", {37'd0, a_fv, a_fa}, 64'd0);
        check("t3.rst_hs", {62'd0, a_ready, a_busy}, 64'd2);
        check("t3.rst_cnt", {a_fills, a_coal}, 64'd0);
        cycle();
        cycle();
        #3 rst = 1'b0;
        fq.delete();
        fe.delete();
        for (int j = 0; j < 30; j++) cycle();
        check("t3.nfill", 64'(fq.size()), 64'd0);
        check("t3.fills", {32'd0, a_fills}, 64'd0);

        // Duplicate line on consecutive edges.
        do_reset();
        a_valid = 1'b1;
        a_addr  = 26'h10; cycle();
        a_addr  = 26'h10; cycle();
        a_addr  = 26'h20; cycle();
        a_valid = 1'b0;
        for (int j = 0; j < 40; j++) cycle();
        check("t4.nfill", 64'(fq.size()), 64'(exp4_n));
        for (int i = 0; i < exp4_n; i++)
            if (i < fq.size()) check("t4.addr", {38'd0, fq[i]}, {38'd0, exp4[i]});
        check("t4.fills", {32'd0, a_fills}, 64'(exp4_n));
        check("t4.coal", {32'd0, a_coal}, 64'(exp4_coal));

        // Random traffic: narrow address pool first, then a wide one.
        do_reset();
        for (int j = 0; j < 400; j++) begin
            a_valid = ($urandom_range(0, 9) < 7);
            a_addr  = (j < 200) ? 26'h200 + 26'($urandom_range(0, 5))
                                : 26'($urandom_range(0, 1000));
            cycle();
        end
        a_valid = 1'b0;
        for (int j = 0; j < 60; j++) cycle();
        check("rand.drained", {63'd0, a_busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
